// File: rtl/taxi_fare_calc_pkg.sv
// Shared widths, FSM state type, default tariff constants and a saturating
// fare adder for the taxi fare stage. The distance stage and the display
// stage use the same constants.
package taxi_pkg;

    localparam int DIST_W = 17;
    localparam int FARE_W = 16;
    localparam int ACC_W  = 18;

    localparam int DEF_BASE_FARE        = 130;
    localparam int DEF_FREE_M           = 3000;
    localparam int DEF_UNIT_M           = 1000;
    localparam int DEF_UNIT_PRICE       = 23;
    localparam int DEF_LOW_PRICE        = 23;
    localparam int DEF_NIGHT_UNIT_PRICE = 28;
    localparam int DEF_FARE_MAX         = 65535;

    typedef enum logic [1:0] {IDLE, RUN, SETTLE, DONE} state_t;

    // Adds inc to fare and clamps the result at ceil.
    function automatic logic [FARE_W-1:0] fare_sat_add(
        input logic [FARE_W-1:0] fare,
        input logic [FARE_W-1:0] inc,
        input logic [FARE_W-1:0] ceil
    );
        logic [FARE_W:0] sum;
        sum = {1'b0, fare} + {1'b0, inc};
        return (sum > {1'b0, ceil}) ? ceil : sum[FARE_W-1:0];
    endfunction

endpackage

// File: rtl/taxi_fare_calc_if.sv
// Bus between the distance/low-speed stage, the fare stage and the display.
// The night signal exists only when TAXI_NIGHT_TARIFF_EN is defined.
interface taxi_fare_calc_if;
    import taxi_pkg::*;

    logic              stop_state;
    logic [DIST_W-1:0] distance;
    logic [DIST_W-1:0] low_time;
`ifdef TAXI_NIGHT_TARIFF_EN
    logic              night;
`endif
    logic [FARE_W-1:0] fare;
    logic              fare_done;
    logic              trip_active;

`ifdef TAXI_NIGHT_TARIFF_EN
    modport master (output stop_state, distance, low_time, night,
                    input  fare, fare_done, trip_active);
    modport slave  (input  stop_state, distance, low_time, night,
                    output fare, fare_done, trip_active);
`else
    modport master (output stop_state, distance, low_time,
                    input  fare, fare_done, trip_active);
    modport slave  (input  stop_state, distance, low_time,
                    output fare, fare_done, trip_active);
`endif

endinterface

// File: rtl/taxi_fare_calc_unit_accum.sv
// Distance-to-unit converter: eats the free distance first, accumulates the
// billable remainder (saturating) and releases at most one unit per cycle.
// half_flag tells the settle logic whether the leftover rounds up.
module taxi_unit_accum
    import taxi_pkg::*;
#(
    parameter int FREE_M = DEF_FREE_M,
    parameter int UNIT_M = DEF_UNIT_M
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              enable,
    input  logic              drain_en,
    input  logic [DIST_W-1:0] delta,
    output logic              unit_stb,
    output logic              whole_flag,
    output logic              half_flag
);

    localparam logic [ACC_W-1:0] UNIT_V = ACC_W'(UNIT_M);
    localparam logic [ACC_W-1:0] HALF_V = ACC_W'(UNIT_M / 2);

    logic [DIST_W-1:0] free_left;
    logic [ACC_W-1:0]  acc;
    logic [DIST_W-1:0] used;
    logic [DIST_W-1:0] rem;
    logic [ACC_W:0]    acc_sum;

    // Split the delta into free and billable parts and form the next acc.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        used       = '0;
        rem        = '0;
        whole_flag = (acc >= UNIT_V);
        half_flag  = (acc >= HALF_V);
        unit_stb   = drain_en && whole_flag;
        if (enable) begin
            if (delta > free_left) begin
                used = free_left;
                rem  = delta - free_left;
            end else begin
                used = delta;
            end
        end
        acc_sum = {1'b0, acc}
                - (unit_stb ? {1'b0, UNIT_V} : '0)
                + {{(ACC_W + 1 - DIST_W){1'b0}}, rem};
    end

    // Free-distance and accumulator registers; clear re-arms them per trip.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop updates from pre-edge values.
        if (!rst_n) begin
            free_left <= '0;
            acc       <= '0;
        end else if (clear) begin
            free_left <= DIST_W'(FREE_M);
            acc       <= '0;
        end else begin
            free_left <= free_left - used;
            acc       <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/taxi_fare_calc.sv
// Taxi fare calculator: base fare, per-kilometre charge and low-speed
// surcharge in dimes, settled with round-half-up when the trip stops.
// Optional macro TAXI_NIGHT_TARIFF_EN adds the night port and the
// NIGHT_UNIT_PRICE parameter (distance price latched at trip start).
module taxi_fare_calc
    import taxi_pkg::*;
#(
    parameter int BASE_FARE  = DEF_BASE_FARE,
    parameter int FREE_M     = DEF_FREE_M,
    parameter int UNIT_M     = DEF_UNIT_M,
    parameter int UNIT_PRICE = DEF_UNIT_PRICE,
    parameter int LOW_PRICE  = DEF_LOW_PRICE,
`ifdef TAXI_NIGHT_TARIFF_EN
    parameter int NIGHT_UNIT_PRICE = DEF_NIGHT_UNIT_PRICE,
`endif
    parameter int FARE_MAX   = DEF_FARE_MAX
) (
    input logic             clk,
    input logic             rst_n,
    taxi_fare_calc_if.slave bus
);

    state_t            state, state_next;
    logic              start, finalize;
    logic              sample, drain_en;
    logic              unit_stb, whole_flag, half_flag;
    logic              low_pending, low_step;
    logic [DIST_W-1:0] dist_prev, low_prev, low_target, low_ref;
    logic [FARE_W-1:0] fare, price, inc;

`ifdef TAXI_NIGHT_TARIFF_EN
    logic night_q;

    // Night tariff is fixed for the whole trip at its start.
    always_ff @(posedge clk) begin
        if (!rst_n)     night_q <= 1'b0;
        else if (start) night_q <= bus.night;
    end

    assign price = night_q ? FARE_W'(NIGHT_UNIT_PRICE) : FARE_W'(UNIT_PRICE);
`else
    assign price = FARE_W'(UNIT_PRICE);
`endif

    // Once stop is seen the inputs are being cleared upstream, so only
    // RUN with stop_state low samples them.
    assign sample      = (state == RUN) && !bus.stop_state;
    assign drain_en    = (state == RUN) || (state == SETTLE);
    assign low_pending = (low_target != low_prev);

    taxi_unit_accum #(
        .FREE_M (FREE_M),
        .UNIT_M (UNIT_M)
    ) u_accum (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start),
        .enable     (sample),
        .drain_en   (drain_en),
        .delta      (bus.distance - dist_prev),
        .unit_stb   (unit_stb),
        .whole_flag (whole_flag),
        .half_flag  (half_flag)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic plus trip start and settle strobes.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        finalize   = 1'b0;
        case (state)
            IDLE: if (!bus.stop_state) begin
                state_next = RUN;
                start      = 1'b1;
            end
            RUN: if (bus.stop_state) state_next = SETTLE;
            SETTLE: if (!whole_flag && !low_pending) begin
                state_next = DONE;
                finalize   = 1'b1;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Low-speed stepping and the fare increment for this cycle.
    always_comb begin
        low_ref  = sample ? bus.low_time : low_target;
        low_step = drain_en && (low_ref != low_prev);
        inc      = '0;
        if (unit_stb)              inc = inc + price;
        if (low_step)              inc = inc + FARE_W'(LOW_PRICE);
        if (finalize && half_flag) inc = inc + price;
    end

    // Fare and input-history registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fare       <= '0;
            dist_prev  <= '0;
            low_prev   <= '0;
            low_target <= '0;
        end else if (start) begin
            fare       <= FARE_W'(BASE_FARE);
            dist_prev  <= '0;
            low_prev   <= '0;
            low_target <= '0;
        end else begin
            if (sample) begin
                dist_prev  <= bus.distance;
                low_target <= bus.low_time;
            end
            if (low_step) low_prev <= low_prev + 1'b1;
            fare <= fare_sat_add(fare, inc, FARE_W'(FARE_MAX));
        end
    end

    assign bus.fare        = fare;
    assign bus.fare_done   = (state == DONE);
    assign bus.trip_active = drain_en;

endmodule
